// File: rtl/fifo_to_axi.sv
// Drains a first-word-fall-through FIFO into memory as AXI INCR write bursts.
// A start/done handshake launches each transfer, and only one burst is outstanding at a time.
module fifo_to_axi #(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 32,
    parameter int LEN_WIDTH      = 16
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        mem_w_start,
    input  logic [AXI_ADDR_WIDTH-1:0]   mem_w_addr,
    input  logic [LEN_WIDTH-1:0]        mem_w_len,
    output logic                        mem_w_busy,
    output logic                        mem_w_done,
    output logic                        mem_w_error,
    output logic                        fifo_rd_en,
    input  logic [AXI_DATA_WIDTH-1:0]   fifo_rd_data,
    input  logic                        fifo_empty,
    output logic                        axi_awvalid,
    input  logic                        axi_awready,
    output logic [AXI_ADDR_WIDTH-1:0]   axi_awaddr,
    output logic [7:0]                  axi_awlen,
    output logic [2:0]                  axi_awsize,
    output logic [1:0]                  axi_awburst,
    output logic [3:0]                  axi_awid,
    output logic                        axi_awlock,
    output logic [2:0]                  axi_awprot,
    output logic [3:0]                  axi_awqos,
    output logic                        axi_wvalid,
    input  logic                        axi_wready,
    output logic [AXI_DATA_WIDTH-1:0]   axi_wdata,
    output logic [AXI_DATA_WIDTH/8-1:0] axi_wstrb,
    output logic                        axi_wlast,
    input  logic                        axi_bvalid,
    output logic                        axi_bready,
    input  logic [1:0]                  axi_bresp
);

    localparam int BYTES       = AXI_DATA_WIDTH / 8;
    localparam int ALIGN_WIDTH = $clog2(BYTES);
    localparam int BEAT_WIDTH  = LEN_WIDTH - ALIGN_WIDTH + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_AW   = 2'd1,
        ST_W    = 2'd2,
        ST_B    = 2'd3
    } state_t;

    state_t                    state_r, state_next_s;
    logic [AXI_ADDR_WIDTH-1:0] addr_r;
    logic [BEAT_WIDTH-1:0]     rem_r;
    logic [BEAT_WIDTH-1:0]     cnt_r;
    logic [8:0]                burst_r;
    logic [ALIGN_WIDTH-1:0]    last_bytes_r;
    logic                      err_r;
    logic                      awvalid_r;
    logic [7:0]                awlen_r;
    logic                      busy_r;
    logic                      done_r;
    logic                      error_r;

    logic [LEN_WIDTH:0]        len_round_s;
    logic [BEAT_WIDTH-1:0]     total_s;
    logic [12:0]               to_4k_s;
    logic [12:0]               beats_4k_s;
    logic [12:0]               cap_s;
    logic [8:0]                burst_s;
    logic                      wvalid_s;
    logic                      aw_hs_s;
    logic                      w_hs_s;
    logic                      b_hs_s;
    logic                      bresp_err_s;

    // Byte enables for a partial final word: the low nbytes lanes, or all lanes when nbytes is zero.
    function automatic logic [BYTES-1:0] strb_mask(input logic [ALIGN_WIDTH-1:0] nbytes);
        logic [BYTES-1:0] m;
        for (int i = 0; i < BYTES; i++) begin
            m[i] = (nbytes == {ALIGN_WIDTH{1'b0}}) || (i < int'(nbytes));
        end
        return m;
    endfunction

    assign len_round_s = {1'b0, mem_w_len} + (LEN_WIDTH+1)'(BYTES - 1);
    assign total_s     = BEAT_WIDTH'(len_round_s >> ALIGN_WIDTH);
    assign to_4k_s     = 13'h1000 - {1'b0, addr_r[11:0]};
    assign beats_4k_s  = to_4k_s >> ALIGN_WIDTH;
    assign wvalid_s    = (state_r == ST_W) && !fifo_empty;
    assign aw_hs_s     = awvalid_r && axi_awready;
    assign w_hs_s      = wvalid_s && axi_wready;
    assign b_hs_s      = (state_r == ST_B) && axi_bvalid;
    assign bresp_err_s = (axi_bresp != 2'b00);

    // Burst length: the smallest of 256, the beats still owed, and the beats left before the 4 KiB line.
    always_comb begin
        cap_s   = (beats_4k_s < 13'd256) ? beats_4k_s : 13'd256;
        burst_s = 9'd0;
        if (32'(rem_r) < 32'(cap_s)) begin
            burst_s = 9'(rem_r);
        end else begin
            burst_s = 9'(cap_s);
        end
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (mem_w_start && (mem_w_len != {LEN_WIDTH{1'b0}})) begin
                    state_next_s = ST_AW;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_AW: begin
                if (aw_hs_s) begin
                    state_next_s = ST_W;
                end else begin
                    state_next_s = ST_AW;
                end
            end
            ST_W: begin
                if (w_hs_s && (cnt_r == BEAT_WIDTH'(1'b1))) begin
                    state_next_s = ST_B;
                end else begin
                    state_next_s = ST_W;
                end
            end
            ST_B: begin
                if (b_hs_s) begin
                    state_next_s = (rem_r != {BEAT_WIDTH{1'b0}}) ? ST_AW : ST_IDLE;
                end else begin
                    state_next_s = ST_B;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Transfer bookkeeping, AW registers and the status outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            addr_r       <= {AXI_ADDR_WIDTH{1'b0}};
            rem_r        <= {BEAT_WIDTH{1'b0}};
            cnt_r        <= {BEAT_WIDTH{1'b0}};
            burst_r      <= 9'd0;
            last_bytes_r <= {ALIGN_WIDTH{1'b0}};
            err_r        <= 1'b0;
            awvalid_r    <= 1'b0;
            awlen_r      <= 8'd0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            error_r      <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (mem_w_start) begin
                        if (mem_w_len == {LEN_WIDTH{1'b0}}) begin
                            done_r  <= 1'b1;
                            error_r <= 1'b1;
                        end else begin
                            addr_r       <= mem_w_addr;
                            rem_r        <= total_s;
                            last_bytes_r <= mem_w_len[ALIGN_WIDTH-1:0];
                            err_r        <= 1'b0;
                            busy_r       <= 1'b1;
                        end
                    end
                end
                ST_AW: begin
                    // The first AW cycle sizes the burst; awvalid follows a cycle later.
                    if (!awvalid_r) begin
                        awvalid_r <= 1'b1;
                        awlen_r   <= 8'(burst_s - 9'd1);
                        burst_r   <= burst_s;
                        cnt_r     <= BEAT_WIDTH'(burst_s);
                    end else if (axi_awready) begin
                        awvalid_r <= 1'b0;
                    end
                end
                ST_W: begin
                    if (w_hs_s) begin
                        cnt_r <= cnt_r - BEAT_WIDTH'(1'b1);
                        rem_r <= rem_r - BEAT_WIDTH'(1'b1);
                    end
                end
                ST_B: begin
                    if (b_hs_s) begin
                        err_r  <= err_r | bresp_err_s;
                        addr_r <= addr_r + (AXI_ADDR_WIDTH'(burst_r) << ALIGN_WIDTH);
                        if (rem_r == {BEAT_WIDTH{1'b0}}) begin
                            done_r  <= 1'b1;
                            error_r <= err_r | bresp_err_s;
                            busy_r  <= 1'b0;
                        end
                    end
                end
                default: begin
                    awvalid_r <= 1'b0;
                end
            endcase
        end
    end

    assign mem_w_busy  = busy_r;
    assign mem_w_done  = done_r;
    assign mem_w_error = error_r;
    assign fifo_rd_en  = w_hs_s;
    assign axi_awvalid = awvalid_r;
    assign axi_awaddr  = addr_r;
    assign axi_awlen   = awlen_r;
    assign axi_awsize  = 3'(ALIGN_WIDTH);
    assign axi_awburst = 2'b01;
    assign axi_awid    = 4'd0;
    assign axi_awlock  = 1'b0;
    assign axi_awprot  = 3'd0;
    assign axi_awqos   = 4'd0;
    assign axi_wvalid  = wvalid_s;
    assign axi_wdata   = fifo_rd_data;
    assign axi_wstrb   = (rem_r == BEAT_WIDTH'(1'b1)) ? strb_mask(last_bytes_r) : {BYTES{1'b1}};
    assign axi_wlast   = (state_r == ST_W) && (cnt_r == BEAT_WIDTH'(1'b1));
    assign axi_bready  = (state_r == ST_B);

endmodule

// File: tb/tb_fifo_to_axi.sv
// Directed bench for fifo_to_axi: a counting FIFO model, an always-ready AXI slave,
// and immediate-assertion checks along one linear stimulus sequence.
module tb_fifo_to_axi;

    logic        clock = 1'b0;
    logic        reset;
    logic        mem_w_start;
    logic [31:0] mem_w_addr;
    logic [15:0] mem_w_len;
    logic        mem_w_busy, mem_w_done, mem_w_error;
    logic        fifo_rd_en;
    logic [31:0] fifo_rd_data;
    logic        fifo_empty;
    logic        axi_awvalid, axi_awready;
    logic [31:0] axi_awaddr;
    logic [7:0]  axi_awlen;
    logic [2:0]  axi_awsize;
    logic [1:0]  axi_awburst;
    logic [3:0]  axi_awid;
    logic        axi_awlock;
    logic [2:0]  axi_awprot;
    logic [3:0]  axi_awqos;
    logic        axi_wvalid, axi_wready;
    logic [31:0] axi_wdata;
    logic [3:0]  axi_wstrb;
    logic        axi_wlast;
    logic        axi_bvalid, axi_bready;
    logic [1:0]  axi_bresp;

    fifo_to_axi dut (
        .clock(clock), .reset(reset),
        .mem_w_start(mem_w_start), .mem_w_addr(mem_w_addr), .mem_w_len(mem_w_len),
        .mem_w_busy(mem_w_busy), .mem_w_done(mem_w_done), .mem_w_error(mem_w_error),
        .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data), .fifo_empty(fifo_empty),
        .axi_awvalid(axi_awvalid), .axi_awready(axi_awready), .axi_awaddr(axi_awaddr),
        .axi_awlen(axi_awlen), .axi_awsize(axi_awsize), .axi_awburst(axi_awburst),
        .axi_awid(axi_awid), .axi_awlock(axi_awlock), .axi_awprot(axi_awprot),
        .axi_awqos(axi_awqos),
        .axi_wvalid(axi_wvalid), .axi_wready(axi_wready), .axi_wdata(axi_wdata),
        .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
        .axi_bvalid(axi_bvalid), .axi_bready(axi_bready), .axi_bresp(axi_bresp)
    );

    always #5 clock = ~clock;

    // FIFO model: word k holds 0xA5000000+k; it holds wr_ptr-rd_ptr words.
    int rd_ptr = 0;
    int wr_ptr = 0;
    assign fifo_rd_data = 32'hA500_0000 + 32'(rd_ptr);
    assign fifo_empty   = (rd_ptr == wr_ptr);

    always @(posedge clock) begin
        if (fifo_rd_en) rd_ptr <= rd_ptr + 1;
    end

    // Slave: one B response per wlast; the B numbered err_b_index answers SLVERR.
    logic bvalid_q = 1'b0;
    int   b_cnt = 0;
    int   err_b_index = -1;
    assign axi_bvalid = bvalid_q;
    assign axi_bresp  = (b_cnt == err_b_index) ? 2'b10 : 2'b00;

    always @(posedge clock) begin
        if (reset) begin
            bvalid_q <= 1'b0;
        end else if (axi_wvalid && axi_wready && axi_wlast) begin
            bvalid_q <= 1'b1;
        end else if (bvalid_q && axi_bready) begin
            bvalid_q <= 1'b0;
            b_cnt    <= b_cnt + 1;
        end
    end

    // Monitor: logs AW requests and W beats, and counts ordering and data errors.
    int          aw_cnt = 0, beats = 0, wlast_cnt = 0, partial_cnt = 0;
    int          order_err = 0, data_err = 0, burst_pos = 0, wlast_pos = 0;
    logic [3:0]  last_strb = 4'h0;
    logic [31:0] aw_addr_log [0:63];
    logic [7:0]  aw_len_log  [0:63];

    always @(posedge clock) begin
        if (axi_awvalid && axi_awready) begin
            if (aw_cnt != b_cnt) order_err <= order_err + 1;
            aw_addr_log[aw_cnt % 64] <= axi_awaddr;
            aw_len_log[aw_cnt % 64]  <= axi_awlen;
            aw_cnt    <= aw_cnt + 1;
            burst_pos <= 0;
        end
        if (axi_wvalid && axi_wready) begin
            if (aw_cnt == b_cnt) order_err <= order_err + 1;
            if (axi_wdata !== fifo_rd_data) data_err <= data_err + 1;
            if (axi_wstrb != 4'hF) partial_cnt <= partial_cnt + 1;
            beats     <= beats + 1;
            burst_pos <= burst_pos + 1;
            last_strb <= axi_wstrb;
            if (axi_wlast) begin
                wlast_cnt <= wlast_cnt + 1;
                wlast_pos <= burst_pos + 1;
            end
        end
    end

    int checks = 0;
    int failures = 0;
    int n;
    int aw0, rd0, beats0, partial0, wl0;
    int stall_bad;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic snapshot();
        aw0 = aw_cnt; rd0 = rd_ptr; beats0 = beats; partial0 = partial_cnt; wl0 = wlast_cnt;
    endtask

    task automatic start_xfer(input logic [31:0] addr, input logic [15:0] len);
        @(negedge clock);
        mem_w_start = 1'b1; mem_w_addr = addr; mem_w_len = len;
        @(negedge clock);
        mem_w_start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int k = 0;
        while (mem_w_done !== 1'b1 && k < budget) begin
            @(negedge clock);
            k++;
        end
        check(tag, 64'(mem_w_done), 64'd1);
    endtask

    initial begin
        reset = 1'b1; mem_w_start = 1'b0; mem_w_addr = 32'h0; mem_w_len = 16'h0;
        axi_awready = 1'b1; axi_wready = 1'b1;
        repeat (3) @(negedge clock);
        check("reset_outputs", 64'({axi_awvalid, axi_wvalid, axi_bready, fifo_rd_en,
                                    mem_w_busy, mem_w_done, mem_w_error}), 64'd0);
        reset = 1'b0;

        // Two full words at 0x1000: first awvalid comes 2 cycles after start.
        snapshot(); wr_ptr = rd_ptr + 2;
        start_xfer(32'h1000, 16'd8);
        check("t1_busy", 64'(mem_w_busy), 64'd1);
        check("t1_awvalid_early", 64'(axi_awvalid), 64'd0);
        @(negedge clock);
        check("t1_awvalid_lat", 64'(axi_awvalid), 64'd1);
        check("t1_awaddr", 64'(axi_awaddr), 64'h1000);
        check("t1_awlen", 64'(axi_awlen), 64'd1);
        check("t1_awsize_burst", 64'({axi_awsize, axi_awburst}), 64'({3'd2, 2'b01}));
        wait_done("t1_done", 50);
        check("t1_error", 64'(mem_w_error), 64'd0);
        @(negedge clock);
        check("t1_done_pulse", 64'({mem_w_done, mem_w_busy}), 64'd0);
        check("t1_bursts", 64'(aw_cnt - aw0), 64'd1);
        check("t1_pops", 64'(rd_ptr - rd0), 64'd2);
        check("t1_partial", 64'(partial_cnt - partial0), 64'd0);
        check("t1_last_strb", 64'(last_strb), 64'hF);
        check("t1_wlast_pos", 64'(wlast_pos), 64'd2);

        // Six bytes: final beat carries only two byte lanes.
        snapshot(); wr_ptr = rd_ptr + 2;
        start_xfer(32'h1000, 16'd6);
        wait_done("t2_done", 50);
        check("t2_error", 64'(mem_w_error), 64'd0);
        check("t2_awlen", 64'(aw_len_log[aw0 % 64]), 64'd1);
        check("t2_last_strb", 64'(last_strb), 64'h3);
        check("t2_partial", 64'(partial_cnt - partial0), 64'd1);
        check("t2_wlast_pos", 64'(wlast_pos), 64'd2);
        check("t2_pops", 64'(rd_ptr - rd0), 64'd2);

        // 2048 bytes: two 256-beat bursts; a start while busy is ignored.
        snapshot(); wr_ptr = rd_ptr + 512;
        start_xfer(32'h1000, 16'd2048);
        repeat (5) @(negedge clock);
        mem_w_start = 1'b1; mem_w_addr = 32'h8000; mem_w_len = 16'd4;
        @(negedge clock);
        mem_w_start = 1'b0;
        wait_done("t3_done", 2000);
        check("t3_error", 64'(mem_w_error), 64'd0);
        repeat (5) @(negedge clock);
        check("t3_idle_after", 64'(mem_w_busy), 64'd0);
        check("t3_bursts", 64'(aw_cnt - aw0), 64'd2);
        check("t3_awaddr0", 64'(aw_addr_log[aw0 % 64]), 64'h1000);
        check("t3_awaddr1", 64'(aw_addr_log[(aw0 + 1) % 64]), 64'h1400);
        check("t3_awlen0", 64'(aw_len_log[aw0 % 64]), 64'd255);
        check("t3_awlen1", 64'(aw_len_log[(aw0 + 1) % 64]), 64'd255);
        check("t3_pops", 64'(rd_ptr - rd0), 64'd512);
        check("t3_wlasts", 64'(wlast_cnt - wl0), 64'd2);

        // 4 KiB split: 0x1F00 plus 512 bytes crosses into 0x2000.
        snapshot(); wr_ptr = rd_ptr + 128;
        start_xfer(32'h1F00, 16'd512);
        wait_done("t4_done", 1000);
        check("t4_bursts", 64'(aw_cnt - aw0), 64'd2);
        check("t4_awaddr0", 64'(aw_addr_log[aw0 % 64]), 64'h1F00);
        check("t4_awaddr1", 64'(aw_addr_log[(aw0 + 1) % 64]), 64'h2000);
        check("t4_awlen0", 64'(aw_len_log[aw0 % 64]), 64'd63);
        check("t4_awlen1", 64'(aw_len_log[(aw0 + 1) % 64]), 64'd63);
        check("t4_pops", 64'(rd_ptr - rd0), 64'd128);

        // Zero length: done and error one cycle after start, busy never set, no AXI traffic.
        snapshot();
        start_xfer(32'h3000, 16'd0);
        check("t5_done_err_busy", 64'({mem_w_done, mem_w_error, mem_w_busy}), 64'({1'b1, 1'b1, 1'b0}));
        check("t5_awvalid", 64'(axi_awvalid), 64'd0);
        @(negedge clock);
        check("t5_done_pulse", 64'({mem_w_done, mem_w_busy}), 64'd0);
        repeat (3) @(negedge clock);
        check("t5_no_aw", 64'(aw_cnt - aw0), 64'd0);

        // SLVERR on the first B and a 10-cycle FIFO drought mid-burst.
        snapshot(); err_b_index = b_cnt; wr_ptr = rd_ptr + 100;
        start_xfer(32'h1000, 16'd2048);
        n = 0;
        while ((rd_ptr - rd0) < 100 && n < 1000) begin
            @(negedge clock);
            n++;
        end
        check("t6_drained", 64'(rd_ptr - rd0), 64'd100);
        stall_bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (axi_wvalid !== 1'b0) stall_bad++;
        end
        check("t6_stall_wvalid", 64'(stall_bad), 64'd0);
        check("t6_stall_busy", 64'(mem_w_busy), 64'd1);
        wr_ptr = wr_ptr + 412;
        wait_done("t6_done", 2000);
        check("t6_error", 64'(mem_w_error), 64'd1);
        check("t6_bursts", 64'(aw_cnt - aw0), 64'd2);
        check("t6_pops", 64'(rd_ptr - rd0), 64'd512);
        err_b_index = -1;
        check("order_violations", 64'(order_err), 64'd0);
        check("wdata_errors", 64'(data_err), 64'd0);

        // Reset during the second burst drops every output back to its reset value.
        snapshot(); wr_ptr = rd_ptr + 512;
        start_xfer(32'h4000, 16'd2048);
        n = 0;
        while ((aw_cnt - aw0) < 2 && n < 3000) begin
            @(negedge clock);
            n++;
        end
        check("t7_second_aw", 64'(aw_cnt - aw0), 64'd2);
        repeat (5) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("t7_reset_outputs", 64'({axi_awvalid, axi_wvalid, axi_bready, fifo_rd_en,
                                       mem_w_busy, mem_w_done, mem_w_error}), 64'd0);
        reset = 1'b0; wr_ptr = rd_ptr;
        repeat (3) @(negedge clock);
        check("t7_stays_idle", 64'({axi_awvalid, mem_w_busy}), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fifo_to_axi.md
Name: fifo_to_axi

Overview:
Write-direction counterpart of the FIFO-fed AXI read path. It drains a first-word-fall-through FIFO and writes its contents to memory as AXI INCR write bursts. A memory-write start/done handshake drives it, with the same shape as the read side. It sits between the stream-processor's outbound data FIFO and the AXI write channels (AW/W/B) of the memory interconnect.

Parameters:
AXI_ADDR_WIDTH, 32, AXI address width.
AXI_DATA_WIDTH, 32, AXI data width in bits; legal values are 32, 64, 128. ALIGN_WIDTH = log2(AXI_DATA_WIDTH/8).
LEN_WIDTH, 16, width of the byte-length field.

Ports:
clock  in  1  single clock domain.
reset  in  1  synchronous, active-high.
mem_w_start  in  1  start pulse; sampled only while busy=0.
mem_w_addr  in  AXI_ADDR_WIDTH  destination byte address; must be ALIGN_WIDTH-aligned.
mem_w_len  in  LEN_WIDTH  byte count, 1..2^LEN_WIDTH-1.
mem_w_busy  out  1  transfer in progress.
mem_w_done  out  1  one-cycle completion pulse.
mem_w_error  out  1  status; valid when done is high.
fifo_rd_en  out  1  pops the FIFO head.
fifo_rd_data  in  AXI_DATA_WIDTH  FIFO head word; valid while empty=0.
fifo_empty  in  1  FIFO empty flag.
axi_awvalid, axi_awready  out/in  1  AW handshake.
axi_awaddr  out  AXI_ADDR_WIDTH  burst address.
axi_awlen  out  8  beats-1.
axi_awsize  out  3  log2(AXI_DATA_WIDTH/8).
axi_awburst  out  2  constant 2'b01 (INCR).
axi_awid, axi_awlock, axi_awprot, axi_awqos  out  -  constant 0.
axi_wvalid, axi_wready  out/in  1  W handshake.
axi_wdata  out  AXI_DATA_WIDTH  equals fifo_rd_data.
axi_wstrb  out  AXI_DATA_WIDTH/8  byte enables.
axi_wlast  out  1  last beat of the burst.
axi_bvalid  in  1  B response valid.
axi_bready  out  1  B response ready.
axi_bresp  in  2  B response code.

Behaviour:
- Reset state: awvalid=0, wvalid=0, bready=0, fifo_rd_en=0, busy=0, done=0, error=0. The FSM goes to IDLE. Reset mid-transfer abandons the transfer immediately; no pending AXI beats are completed.
- FSM states are IDLE, AW, W, B.
- IDLE:
  - On start with len=0: next cycle done=1 and error=1; busy stays 0.
  - On start with len>0: latch the address. Compute total_beats = ceil(len / bytes_per_word) and last_bytes = len mod bytes_per_word, where 0 means a full word. Clear err_sticky, set busy=1, go to AW.
- AW:
  - Burst beats = min(256, beats remaining, beats until the next 4 KiB boundary of the current address).
  - awaddr = current address; awlen = beats-1.
  - awvalid rises one cycle after entering AW and stays high until awready. On the handshake cycle go to W.
- W:
  - wvalid = !fifo_empty (combinational); wdata = fifo_rd_data; fifo_rd_en = wvalid & wready.
  - The beat counter decrements on each W handshake. wlast = (beat counter == 1).
  - wstrb is all ones, except on the final beat of the whole transfer when last_bytes≠0; that beat gets the low last_bytes bits set.
  - An empty FIFO stalls with wvalid=0. No bubbles are inserted while data is available.
  - After the wlast handshake go to B.
- B:
  - bready=1. On the bvalid handshake, err_sticky |= (bresp≠2'b00).
  - If beats remain: current address += beats × bytes_per_word, go to AW.
  - Otherwise: done=1 for one cycle, error=err_sticky, busy=0, go to IDLE.
- Ordering:
  - AW is never issued before the previous B is received (one outstanding burst).
  - W data is never sent before its AW handshake.
- A start arriving while busy is ignored.
- Address arithmetic wraps modulo 2^AXI_ADDR_WIDTH.
- Beat counters are LEN_WIDTH-ALIGN_WIDTH+1 bits wide.
- Latency from the start cycle to the first awvalid is 2 cycles.

Test Plan:
- AXI_DATA_WIDTH=32, addr=0x1000, len=8, FIFO prefilled with 2 words, always-ready slave → one burst with awaddr=0x1000 and awlen=1; 2 beats, wstrb=0xF, wlast on beat 2; one B; done=1, error=0.
- addr=0x1000, len=6 → awlen=1; beat 2 has wstrb=0x3 and wlast=1; exactly 2 FIFO pops.
- addr=0x1000, len=2048 → two bursts: awaddr 0x1000 and 0x1400, each awlen=255; the second AW appears only after the first B; 512 pops total.
- addr=0x1F00, len=512 → 4 KiB split into awaddr 0x1F00 with awlen=63, then awaddr 0x2000 with awlen=63.
- len=0 → done=1 and error=1 one cycle after start; no AXI activity; busy never set.
- len=2048, bresp=2'b10 on the first B, FIFO empty for 10 cycles mid-burst → wvalid=0 during the stall; second burst still completes; done with error=1. Asserting reset during the second burst → all outputs return to their reset values on the next cycle.
